// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
package tt_lut_pkg;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam int unsigned MaxOut   = 32;
  localparam int unsigned MaxInitW = 64 * MaxOut;

  function automatic int unsigned rows(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Row 0 sits in the most-significant slice of the init vector.
  function automatic logic [MaxOut-1:0] tt_row(input logic [MaxInitW-1:0] init,
                                               input int unsigned r,
                                               input int unsigned n_out,
                                               input int unsigned n_rows);
    logic [MaxInitW-1:0] sh;
    logic [MaxOut-1:0]   res;
    sh  = init >> ((n_rows - 1 - r) * n_out);
    res = '0;
    for (int unsigned b = 0; b < MaxOut; b++) begin
      if (b < n_out) res[b] = sh[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/tt_out_reg.sv
// Output holding register with valid/ready handshake; loads when empty or draining.
module tt_out_reg #(
  parameter int unsigned BitsW = 1,
  parameter int unsigned RowW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [BitsW-1:0] bits_i,
  input  logic [RowW-1:0]  row_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             load_ok_o,
  output logic             valid_o,
  output logic [BitsW-1:0] bits_o,
  output logic [RowW-1:0]  row_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [BitsW-1:0] bits_q, bits_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             last_q, last_d;

  assign load_ok_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    row_d   = row_q;
    last_d  = last_q;
    if (load_i && load_ok_o) begin
      valid_d = 1'b1;
      bits_d  = bits_i;
      row_d   = row_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
      row_q   <= row_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign bits_o  = bits_q;
  assign row_o   = row_q;
  assign last_o  = last_q;

endmodule

// File: rtl/tt_lut_seq.sv
// Programmable N_IN-input truth table with handshaked evaluation and a self-driven row sweep.
module tt_lut_seq
  import tt_lut_pkg::*;
#(
  parameter int unsigned                N_IN    = 3,
  parameter int unsigned                N_OUT   = 1,
  parameter logic [N_OUT*(1<<N_IN)-1:0] TT_INIT = 8'h22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_bits,
  output logic [N_IN-1:0]  out_row,
  output logic             out_last,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             sweep_start,
  output logic             busy
);

  localparam int unsigned ROWS = rows(N_IN);
  localparam int unsigned CntW = N_IN + 1;

  logic [N_OUT-1:0] table_q [ROWS];
  logic             cfg_we;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             load_ok, load;
  logic [N_OUT-1:0] ld_bits;
  logic [N_IN-1:0]  ld_row;
  logic             ld_last;

  assign cfg_we = cfg_valid && cfg_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [MaxOut-1:0] InitRow = tt_row(MaxInitW'(TT_INIT), r, N_OUT, ROWS);
    logic [N_OUT-1:0] row_q, row_d;

    assign row_d = (cfg_we && cfg_addr == N_IN'(r)) ? cfg_data : row_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) row_q <= InitRow[N_OUT-1:0];
      else        row_q <= row_d;
    end

    assign table_q[r] = row_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    ld_bits   = '0;
    ld_row    = '0;
    ld_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready  = load_ok;
        cfg_ready = 1'b1;
        // Reads use the pre-write table, so a same-cycle write is seen next cycle.
        if (in_valid && load_ok) begin
          load    = 1'b1;
          ld_bits = table_q[in_bits];
          ld_row  = in_bits;
        end else if (sweep_start) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        busy = 1'b1;
        if (load_ok) begin
          load    = 1'b1;
          ld_bits = table_q[cnt_q[N_IN-1:0]];
          ld_row  = cnt_q[N_IN-1:0];
          ld_last = (cnt_q == CntW'(ROWS - 1));
          cnt_d   = cnt_q + 1'b1;
          if (ld_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  tt_out_reg #(
    .BitsW (N_OUT),
    .RowW  (N_IN)
  ) u_out_reg (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (load),
    .bits_i    (ld_bits),
    .row_i     (ld_row),
    .last_i    (ld_last),
    .ready_i   (out_ready),
    .load_ok_o (load_ok),
    .valid_o   (out_valid),
    .bits_o    (out_bits),
    .row_o     (out_row),
    .last_o    (out_last)
  );

endmodule

// File: tb/tb_tt_lut_seq.sv
// Directed self-checking bench for tt_lut_seq (default 3x1 instance plus a 2x2 instance).
module tb_tt_lut_seq;

  logic clk;
  logic rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic       cfg_valid, cfg_ready, sweep_start, busy;
  logic [2:0] in_bits, out_row, cfg_addr;
  logic [0:0] out_bits, cfg_data;

  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last;
  logic       m_cfg_valid, m_cfg_ready, m_sweep_start, m_busy;
  logic [1:0] m_in_bits, m_out_row, m_cfg_addr, m_out_bits, m_cfg_data;

  int checks;
  int failures;

  logic [7:0] def_tt;

  tt_lut_seq #(
    .N_IN    (3),
    .N_OUT   (1),
    .TT_INIT (8'h22)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .out_row     (out_row),
    .out_last    (out_last),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .sweep_start (sweep_start),
    .busy        (busy)
  );

  tt_lut_seq #(
    .N_IN    (2),
    .N_OUT   (2),
    .TT_INIT (8'b00_01_10_11)
  ) dut_m (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (m_in_valid),
    .in_ready    (m_in_ready),
    .in_bits     (m_in_bits),
    .out_valid   (m_out_valid),
    .out_ready   (m_out_ready),
    .out_bits    (m_out_bits),
    .out_row     (m_out_row),
    .out_last    (m_out_last),
    .cfg_valid   (m_cfg_valid),
    .cfg_ready   (m_cfg_ready),
    .cfg_addr    (m_cfg_addr),
    .cfg_data    (m_cfg_data),
    .sweep_start (m_sweep_start),
    .busy        (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_bits = 0; out_ready = 0; cfg_valid = 0; cfg_addr = 0; cfg_data = 0;
    sweep_start = 0;
    m_in_valid = 0; m_in_bits = 0; m_out_ready = 0; m_cfg_valid = 0; m_cfg_addr = 0;
    m_cfg_data = 0; m_sweep_start = 0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_bits !== 1'b0 || out_row !== 3'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: valid=%b bits=%b row=%0d last=%b, required all zero",
               out_valid, out_bits, out_row, out_last);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b in_ready=%b cfg_ready=%b, required 0 1 1",
               busy, in_ready, cfg_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_eval();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bits  = 3'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_bits !== def_tt[7-i] || out_row !== 3'(i) ||
          out_last !== 1'b0) begin
        failures++;
        $display("FAIL eval_row%0d: valid=%b bits=%b row=%0d last=%b, required 1 %b %0d 0",
                 i, out_valid, out_bits, out_row, out_last, def_tt[7-i], i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL eval_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 3'b010;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b1 || out_row !== 3'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_load: valid=%b bits=%b row=%0d in_ready=%b, required 1 1 2 0",
               out_valid, out_bits, out_row, in_ready);
    end
    in_bits = 3'b000;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b1 || out_row !== 3'd2) begin
      failures++;
      $display("FAIL bp_hold: valid=%b bits=%b row=%0d, required 1 1 2",
               out_valid, out_bits, out_row);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b0 || out_row !== 3'd0) begin
      failures++;
      $display("FAIL bp_release: valid=%b bits=%b row=%0d, required 1 0 0",
               out_valid, out_bits, out_row);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int beats;
    bit saw_last;
    beats = 0;
    saw_last = 0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL sweep_enter: busy=%b in_ready=%b cfg_ready=%b, required 1 0 0",
               busy, in_ready, cfg_ready);
    end
    for (int cyc = 0; cyc < 60 && beats < 8; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (busy === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL sweep_ready_low: in_ready=%b cfg_ready=%b, required 0 0",
                   in_ready, cfg_ready);
        end
      end
      if (out_valid === 1'b1 && out_last === 1'b1 && !saw_last) begin
        saw_last = 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL sweep_busy_fall: busy=%b, required 0", busy);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_row !== 3'(beats) || out_bits !== def_tt[7-beats] ||
            out_last !== (beats == 7)) begin
          failures++;
          $display("FAIL sweep_beat%0d: row=%0d bits=%b last=%b, required %0d %b %b",
                   beats, out_row, out_bits, out_last, beats, def_tt[7-beats], beats == 7);
        end
        beats++;
      end
      step();
    end
    checks++;
    if (beats != 8) begin
      failures++;
      $display("FAIL sweep_count: beats=%0d, required 8", beats);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL sweep_exit: busy=%b out_valid=%b in_ready=%b, required 0 0 1",
               busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reprogram();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 3'b000;
    cfg_valid = 1'b1;
    cfg_addr  = 3'b000;
    cfg_data  = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b0) begin
      failures++;
      $display("FAIL reprog_same_cycle: valid=%b bits=%b, required 1 0", out_valid, out_bits);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b1 || out_row !== 3'd0) begin
      failures++;
      $display("FAIL reprog_next: valid=%b bits=%b row=%0d, required 1 1 0",
               out_valid, out_bits, out_row);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_midsweep_reset();
    bit found;
    found = 0;
    out_ready = 1'b1;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      step();
      if (out_valid === 1'b1 && out_row === 3'd0) begin
        checks++;
        if (out_bits !== 1'b1) begin
          failures++;
          $display("FAIL midsweep_row0: bits=%b, required 1", out_bits);
        end
      end
      if (out_valid === 1'b1 && out_row === 3'd4) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midsweep_reach4: row 4 not seen, required within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_row !== 3'd0) begin
      failures++;
      $display("FAIL midsweep_abort: valid=%b busy=%b row=%0d, required 0 0 0",
               out_valid, busy, out_row);
    end
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_bits  = 3'b000;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_table_restored: valid=%b bits=%b, required 1 0",
               out_valid, out_bits);
    end
    step();
  endtask

  task automatic test_multi_out();
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_in_valid = 1'b1;
      m_in_bits  = 2'(i);
      step();
      checks++;
      if (m_out_valid !== 1'b1 || m_out_bits !== 2'(i) || m_out_row !== 2'(i)) begin
        failures++;
        $display("FAIL multi_row%0d: valid=%b bits=%b row=%0d, required 1 %b %0d",
                 i, m_out_valid, m_out_bits, m_out_row, 2'(i), i);
      end
    end
    m_in_valid = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    def_tt   = 8'h22;
    test_reset();
    test_eval();
    test_backpressure();
    test_sweep();
    test_reprogram();
    test_midsweep_reset();
    test_multi_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
